sl3p_link_ctrl_nln_fec: RTL

- Bring-up, health-monitor and retrain controller for an N-lane armored66 FEC SERDES link.
- Runs on the management clock. Sequences calibration wait, reset hold, TX PLL lock and deskew lock.
- Watches per-lane FEC fix/fail events and forces a relink when the windowed fail count crosses a threshold.
- Has a bounded retry budget, then gives up until software intervenes.

---
 rtl/sl3p_link_pkg.sv | 27 ++
 rtl/sl3p_lane_err_stats.sv | 33 +++
 rtl/sl3p_link_ctrl_nln_fec.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/sl3p_link_pkg.sv
// Shared encodings for the armored66 link controller: FSM states, relink causes
// and a small popcount helper for the per-lane error pulses.
package sl3p_link_pkg;

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] CAL_WAIT  = 3'd1;
  localparam logic [2:0] RST_HOLD  = 3'd2;
  localparam logic [2:0] PLL_WAIT  = 3'd3;
  localparam logic [2:0] LOCK_WAIT = 3'd4;
  localparam logic [2:0] UP        = 3'd5;
  localparam logic [2:0] BACKOFF   = 3'd6;
  localparam logic [2:0] DEAD      = 3'd7;

  localparam logic [1:0] CAUSE_NONE  = 2'd0;
  localparam logic [1:0] CAUSE_LOCK  = 2'd1;
  localparam logic [1:0] CAUSE_ERR   = 2'd2;
  localparam logic [1:0] CAUSE_FORCE = 2'd3;

  // Lane vectors are zero-extended to 16 bits, the maximum lane count.
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) n = n + 5'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/sl3p_lane_err_stats.sv
// One lane's saturating corrected/uncorrected FEC event counters; clear beats
// a same-cycle increment.
module sl3p_lane_err_stats #(
  parameter int ERR_BITS = 16
) (
  input  logic                clk100,
  input  logic                rst100,
  input  logic                inc_en,
  input  logic                fix,
  input  logic                fail,
  input  logic                clr,
  output logic [ERR_BITS-1:0] fix_cnt,
  output logic [ERR_BITS-1:0] fail_cnt
);

  logic [ERR_BITS-1:0] fix_q, fail_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk100) begin
    if (rst100 || clr) begin
      fix_q  <= '0;
      fail_q <= '0;
    end else if (inc_en) begin
      if (fix && (fix_q != '1))   fix_q  <= fix_q + 1'b1;
      if (fail && (fail_q != '1)) fail_q <= fail_q + 1'b1;
    end
  end

  assign fix_cnt  = fix_q;
  assign fail_cnt = fail_q;

endmodule

// File: rtl/sl3p_link_ctrl_nln_fec.sv
// Bring-up, FEC health monitor and bounded-retry relink controller for an
// N-lane armored66 SERDES link, clocked by the management clock.
module sl3p_link_ctrl_nln_fec
  import sl3p_link_pkg::*;
#(
  parameter int NUM_LN      = 4,
  parameter int CNTR_BITS   = 16,
  parameter int TMO_BITS    = 20,
  parameter int WIN_BITS    = 20,
  parameter int ERR_BITS    = 16,
  parameter int FAIL_THRESH = 8,
  parameter int RETRY_BITS  = 3,
  parameter int MAX_RETRIES = 5
) (
  input  logic                       clk100,
  input  logic                       rst100,
  input  logic                       enable,
  input  logic                       cal_busy,
  input  logic                       force_relink,
  input  logic                       clr_cnt,
  input  logic [NUM_LN-1:0]          tx_pll_locked,
  input  logic                       deskew_locked,
  input  logic [NUM_LN-1:0]          fix_pulse,
  input  logic [NUM_LN-1:0]          fail_pulse,
  output logic                       xcvr_rst,
  output logic                       link_up,
  output logic                       gave_up,
  output logic [2:0]                 state,
  output logic [RETRY_BITS-1:0]      retry_cnt,
  output logic [NUM_LN*ERR_BITS-1:0] fix_cnt,
  output logic [NUM_LN*ERR_BITS-1:0] fail_cnt,
  output logic [1:0]                 last_cause
);

  // One timer serves reset hold, backoff and lock timeout; it restarts on every state change.
  localparam int TMR_W = (CNTR_BITS > TMO_BITS) ? CNTR_BITS : TMO_BITS;
  localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'((64'd1 << CNTR_BITS) - 64'd1);
  localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'((64'd1 << TMO_BITS) - 64'd1);
  localparam int ACC_W = $clog2(FAIL_THRESH + 1);

  logic [2:0]            state_q, state_d;
  logic [TMR_W-1:0]      tmr_q, tmr_d;
  logic [WIN_BITS-1:0]   win_q, win_d;
  logic [ACC_W-1:0]      acc_q, acc_d, acc_base, acc_now;
  logic [RETRY_BITS-1:0] retry_q, retry_d;
  logic [1:0]            cause_q, cause_d;
  logic                  xcvr_rst_q, xcvr_rst_d;
  logic                  link_up_q, link_up_d;
  logic                  gave_up_q, gave_up_d;

  logic [4:0]  fail_pop;
  logic [31:0] acc_sum;
  logic        all_pll, hold_done, tmo, lock_lost, err_hit, in_up;

  assign all_pll   = &tx_pll_locked;
  assign hold_done = (tmr_q == HOLD_LAST);
  assign tmo       = (tmr_q == TMO_LAST);
  assign lock_lost = !deskew_locked || !all_pll;
  assign in_up     = (state_q == UP);
  assign fail_pop  = popcount16(16'(fail_pulse));

  // Window accumulator including this cycle's pulses; a wrap cycle starts from zero.
  always_comb begin
    acc_base = (win_q == '0) ? '0 : acc_q;
    acc_sum  = 32'(acc_base) + 32'(fail_pop);
    acc_now  = (acc_sum >= 32'(FAIL_THRESH)) ? ACC_W'(FAIL_THRESH) : ACC_W'(acc_sum);
    err_hit  = (32'(acc_now) >= 32'(FAIL_THRESH));
  end

  // NOTE: every signal written in an always_comb gets a default first so no
  // path through the block can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (enable) state_d = CAL_WAIT;
      CAL_WAIT:  if (!cal_busy) state_d = RST_HOLD;
      RST_HOLD:  if (cal_busy) state_d = CAL_WAIT;
                 else if (hold_done) state_d = PLL_WAIT;
      PLL_WAIT:  if (all_pll) state_d = LOCK_WAIT;
                 else if (tmo) state_d = BACKOFF;
      LOCK_WAIT: if (!all_pll || tmo) state_d = BACKOFF;
                 else if (deskew_locked) state_d = UP;
      UP:        if (lock_lost || err_hit || force_relink) state_d = BACKOFF;
      BACKOFF:   if (retry_q == RETRY_BITS'(MAX_RETRIES)) state_d = DEAD;
                 else if (hold_done) state_d = CAL_WAIT;
      DEAD:      if (force_relink) state_d = CAL_WAIT;
      default:   state_d = IDLE;
    endcase
    if (!enable) state_d = IDLE;
  end

  always_comb begin
    tmr_d   = (state_d != state_q) ? '0 : tmr_q + 1'b1;
    win_d   = (in_up && state_d == UP) ? win_q + 1'b1 : '0;
    acc_d   = in_up ? acc_now : '0;
    retry_d = retry_q;
    cause_d = cause_q;
    if (in_up && win_q == '1 && acc_now == '0) retry_d = '0;
    if (state_d == BACKOFF && state_q != BACKOFF) retry_d = retry_q + 1'b1;
    if (in_up && state_d == BACKOFF) begin
      if (lock_lost)    cause_d = CAUSE_LOCK;
      else if (err_hit) cause_d = CAUSE_ERR;
      else              cause_d = CAUSE_FORCE;
    end
    if (state_q == DEAD && state_d == CAL_WAIT) retry_d = '0;
    if (!enable) begin
      retry_d = '0;
      cause_d = CAUSE_NONE;
    end
  end

  // Outputs decode the next state so they register in step with state_q.
  always_comb begin
    xcvr_rst_d = !(state_d == PLL_WAIT || state_d == LOCK_WAIT || state_d == UP);
    link_up_d  = (state_d == UP);
    gave_up_d  = (state_d == DEAD);
  end

  always_ff @(posedge clk100) begin
    if (rst100) begin
      state_q    <= IDLE;
      tmr_q      <= '0;
      win_q      <= '0;
      acc_q      <= '0;
      retry_q    <= '0;
      cause_q    <= CAUSE_NONE;
      xcvr_rst_q <= 1'b1;
      link_up_q  <= 1'b0;
      gave_up_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      win_q      <= win_d;
      acc_q      <= acc_d;
      retry_q    <= retry_d;
      cause_q    <= cause_d;
      xcvr_rst_q <= xcvr_rst_d;
      link_up_q  <= link_up_d;
      gave_up_q  <= gave_up_d;
    end
  end

  for (genvar i = 0; i < NUM_LN; i++) begin : g_lane
    sl3p_lane_err_stats #(.ERR_BITS(ERR_BITS)) u_stats (
      .clk100   (clk100),
      .rst100   (rst100),
      .inc_en   (in_up),
      .fix      (fix_pulse[i]),
      .fail     (fail_pulse[i]),
      .clr      (clr_cnt),
      .fix_cnt  (fix_cnt[i*ERR_BITS +: ERR_BITS]),
      .fail_cnt (fail_cnt[i*ERR_BITS +: ERR_BITS])
    );
  end

  assign state      = state_q;
  assign xcvr_rst   = xcvr_rst_q;
  assign link_up    = link_up_q;
  assign gave_up    = gave_up_q;
  assign retry_cnt  = retry_q;
  assign last_cause = cause_q;

endmodule
